uart_tx_top: RTL and testbench



---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx_top_if.sv | 29 ++
 rtl/uart_tx_top.sv | 143 ++++++++++++++
 tb/tb_uart_tx_top.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line-control word-length codes,
// data-width mask and the parity rule, common to transmitter and receiver.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   typedef logic [1:0] wls_t;

   localparam wls_t WLS_5 = 2'b00;
   localparam wls_t WLS_6 = 2'b01;
   localparam wls_t WLS_7 = 2'b10;
   localparam wls_t WLS_8 = 2'b11;

   localparam int OSR_DEFAULT = 16;

   function automatic logic [7:0] word_mask(input wls_t wls);
      logic [7:0] m;
      case (wls)
         WLS_5:   m = 8'h1F;
         WLS_6:   m = 8'h3F;
         WLS_7:   m = 8'h7F;
         WLS_8:   m = 8'hFF;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Bits above the word length never contribute to parity.
   function automatic logic parity_bit(input logic [7:0] data, input wls_t wls,
                                       input logic eps, input logic sticky);
      logic [7:0] d;
      d = data & word_mask(wls);
      if (sticky)
         return ~eps;
      return eps ? ^d : ~^d;
   endfunction

endpackage

// File: rtl/uart_tx_top_if.sv
// Transmitter signal bundle: baud tick, FIFO head/pop, line-control fields and the serial line.
// master drives the FIFO/LCR side; slave is the transmitter itself.
interface uart_tx_top_if;
   import uart_pkg::*;

   logic       baud_pulse;
   logic       fifo_empty;
   logic [7:0] din;
   wls_t       wls;
   logic       stb;
   logic       pen;
   logic       eps;
   logic       sticky_parity;
   logic       brk;
   logic       pop;
   logic       tx;
   logic       busy;

   modport master (
      output baud_pulse, fifo_empty, din, wls, stb, pen, eps, sticky_parity, brk,
      input  pop, tx, busy
   );

   modport slave (
      input  baud_pulse, fifo_empty, din, wls, stb, pen, eps, sticky_parity, brk,
      output pop, tx, busy
   );

endinterface

// File: rtl/uart_tx_top.sv
// 16550-style serialiser: pops the FIFO head on a baud tick, start bit on tx one clk later.
// Frames chain with no idle gap; an empty FIFO simply leaves the line idle high.
module uart_tx_top
   import uart_pkg::*;
#(
   parameter int OSR = OSR_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_top_if.slave bus
);

   localparam int            CW          = $clog2(2 * OSR);
   localparam logic [CW-1:0] BIT_LAST    = CW'(OSR - 1);
   localparam logic [CW-1:0] STOP15_LAST = CW'(OSR * 3 / 2 - 1);
   localparam logic [CW-1:0] STOP2_LAST  = CW'(2 * OSR - 1);

   state_t        state, state_d;
   logic [CW-1:0] count, count_d;
   logic [2:0]    bitcnt, bitcnt_d;
   logic [7:0]    shreg, shreg_d;
   wls_t          f_wls, f_wls_d;
   logic          f_stb, f_stb_d;
   logic          f_pen, f_pen_d;
   logic          par, par_d;
   logic          load;
   logic          tx_d;
   logic          tx_q;
   logic [CW-1:0] stop_last;

   // Stop length uses the latched fields so LCR writes only affect the next frame.
   assign stop_last = !f_stb            ? BIT_LAST :
                      (f_wls == WLS_5)  ? STOP15_LAST : STOP2_LAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         bitcnt <= '0;
         shreg  <= '0;
         f_wls  <= WLS_5;
         f_stb  <= 1'b0;
         f_pen  <= 1'b0;
         par    <= 1'b0;
         tx_q   <= 1'b1;
      end else begin
         state  <= state_d;
         count  <= count_d;
         bitcnt <= bitcnt_d;
         shreg  <= shreg_d;
         f_wls  <= f_wls_d;
         f_stb  <= f_stb_d;
         f_pen  <= f_pen_d;
         par    <= par_d;
         tx_q   <= bus.brk ? 1'b0 : tx_d;
      end
   end

   always_comb begin
      state_d  = state;
      count_d  = count;
      bitcnt_d = bitcnt;
      shreg_d  = shreg;
      f_wls_d  = f_wls;
      f_stb_d  = f_stb;
      f_pen_d  = f_pen;
      par_d    = par;
      load     = 1'b0;
      if (bus.baud_pulse) begin
         unique case (state)
            IDLE: load = !bus.fifo_empty;
            START: begin
               if (count == '0) begin
                  state_d  = DATA;
                  count_d  = BIT_LAST;
                  bitcnt_d = {1'b0, f_wls} + 3'd4;
               end else begin
                  count_d = count - CW'(1);
               end
            end
            DATA: begin
               if (count == '0) begin
                  shreg_d = {1'b0, shreg[7:1]};
                  if (bitcnt != 3'd0) begin
                     bitcnt_d = bitcnt - 3'd1;
                     count_d  = BIT_LAST;
                  end else if (f_pen) begin
                     state_d = PARITY;
                     count_d = BIT_LAST;
                  end else begin
                     state_d = STOP;
                     count_d = stop_last;
                  end
               end else begin
                  count_d = count - CW'(1);
               end
            end
            PARITY: begin
               if (count == '0) begin
                  state_d = STOP;
                  count_d = stop_last;
               end else begin
                  count_d = count - CW'(1);
               end
            end
            STOP: begin
               if (count != '0)
                  count_d = count - CW'(1);
               else if (!bus.fifo_empty)
                  load = 1'b1;
               else
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      if (load) begin
         state_d = START;
         count_d = BIT_LAST;
         shreg_d = bus.din;
         f_wls_d = bus.wls;
         f_stb_d = bus.stb;
         f_pen_d = bus.pen;
         par_d   = parity_bit(bus.din, bus.wls, bus.eps, bus.sticky_parity);
      end
   end

   // tx is registered from next-state values so the start bit follows the pop by one clk.
   always_comb begin
      bus.pop  = load & ~rst;
      bus.busy = (state != IDLE);
      tx_d     = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   assign bus.tx = tx_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: frame formats, parity modes, chaining, break, reset and tick gaps.
// Expected line levels come from a pulse-counting frame model fed with hand-computed bit lists.
module tb_uart_tx_top;

   localparam int OSR  = 16;
   localparam int TMAX = 400;

   logic clk;
   logic rst;

   uart_tx_top_if bus();

   uart_tx_top #(.OSR(OSR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] q[$];
   logic       tr_tx   [TMAX];
   logic       tr_busy [TMAX];
   logic       tr_pop  [TMAX];
   logic       tr_baud [TMAX];
   int         rst_on, rst_off, brk_on, brk_off, frz_on, frz_off, chg_at;
   logic [5:0] lcr_a, lcr_b;   // {wls, stb, pen, eps, sticky}
   logic [15:0] fb;
   int          nb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic setup(input logic [5:0] lcr);
      lcr_a   = lcr;
      lcr_b   = lcr;
      chg_at  = TMAX;
      rst_on  = 0; rst_off = 0;
      brk_on  = 0; brk_off = 0;
      frz_on  = 0; frz_off = 0;
   endtask

   // One trace slot per clk: drive inputs, sample at negedge, retire popped byte after the edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         logic [5:0] lcr;
         lcr                = (i >= chg_at) ? lcr_b : lcr_a;
         bus.wls            = lcr[5:4];
         bus.stb            = lcr[3];
         bus.pen            = lcr[2];
         bus.eps            = lcr[1];
         bus.sticky_parity  = lcr[0];
         bus.fifo_empty     = (q.size() == 0);
         bus.din            = (q.size() != 0) ? q[0] : 8'h00;
         bus.brk            = (i >= brk_on && i < brk_off);
         bus.baud_pulse     = !(i >= frz_on && i < frz_off);
         rst                = (i >= rst_on && i < rst_off);
         tr_baud[i]         = bus.baud_pulse & ~rst;
         @(negedge clk);
         tr_tx[i]   = bus.tx;
         tr_busy[i] = bus.busy;
         tr_pop[i]  = bus.pop;
         @(posedge clk);
         #1;
         if (tr_pop[i] === 1'b1 && q.size() != 0)
            void'(q.pop_front());
      end
   endtask

   task automatic set_frame(input logic [7:0] data, input int ndata, input int haspar,
                            input logic p);
      fb = '0;
      for (int k = 0; k < ndata; k++)
         fb[1 + k] = data[k];
      if (haspar != 0)
         fb[1 + ndata] = p;
      nb = 1 + ndata + haspar;
   endtask

   function automatic logic exp_tx(input int base, input int i);
      int m;
      m = 0;
      for (int j = base + 1; j < i; j++)
         if (tr_baud[j] === 1'b1)
            m++;
      if (m < OSR * nb)
         return fb[m / OSR];
      return 1'b1;
   endfunction

   task automatic check_tx(input string tag, input int base, input int lo, input int hi);
      int mism;
      mism = 0;
      for (int i = lo; i <= hi; i++)
         if (tr_tx[i] !== exp_tx(base, i))
            mism++;
      chk(tag, mism, 0);
   endtask

   function automatic int ones(input int sel, input int lo, input int hi);
      int c;
      c = 0;
      for (int i = lo; i <= hi; i++) begin
         if (sel == 0 && tr_tx[i] === 1'b1)   c++;
         if (sel == 1 && tr_busy[i] === 1'b1) c++;
         if (sel == 2 && tr_pop[i] === 1'b1)  c++;
      end
      return c;
   endfunction

   initial begin
      rst                = 1'b1;
      bus.baud_pulse     = 1'b0;
      bus.fifo_empty     = 1'b1;
      bus.din            = 8'h00;
      bus.wls            = 2'b00;
      bus.stb            = 1'b0;
      bus.pen            = 1'b0;
      bus.eps            = 1'b0;
      bus.sticky_parity  = 1'b0;
      bus.brk            = 1'b0;
      @(posedge clk);
      #1;

      // Reset held with a byte waiting and ticks running: no pop, line idle.
      setup(6'b11_0_0_0_0);
      q.push_back(8'h55);
      rst_on = 0; rst_off = 3;
      run(3);
      chk("rst_tx", tr_tx[2], 1);
      chk("rst_busy", tr_busy[2], 0);
      chk("rst_pop", ones(2, 0, 2), 0);

      // 8N1, 0x55
      setup(6'b11_0_0_0_0);
      set_frame(8'h55, 8, 0, 1'b0);
      run(170);
      chk("8n1_pop0", tr_pop[0], 1);
      chk("8n1_pops", ones(2, 0, 169), 1);
      check_tx("8n1_line", 0, 1, 169);
      chk("8n1_busy0", tr_busy[0], 0);
      chk("8n1_busy1", tr_busy[1], 1);
      chk("8n1_busy160", tr_busy[160], 1);
      chk("8n1_busy161", tr_busy[161], 0);

      // 5O1.5, 0xE3, with a 10-clk tick gap mid-data
      setup(6'b00_1_1_0_0);
      q.push_back(8'hE3);
      frz_on = 50; frz_off = 60;
      set_frame(8'hE3, 5, 1, 1'b1);
      run(150);
      check_tx("5o15_line", 0, 1, 149);
      chk("5o15_pops", ones(2, 0, 149), 1);
      chk("5o15_busy146", tr_busy[146], 1);
      chk("5o15_busy147", tr_busy[147], 0);

      // 7-bit sticky parity, eps=1 -> parity 0
      setup(6'b10_0_1_1_1);
      q.push_back(8'h7F);
      set_frame(8'h7F, 7, 1, 1'b0);
      run(165);
      check_tx("stk1_line", 0, 1, 164);
      chk("stk1_par", tr_tx[136], 0);
      chk("stk1_busy161", tr_busy[161], 0);

      // sticky, eps=0 -> parity 1; LCR rewritten mid-frame must not alter this frame
      setup(6'b10_0_1_0_1);
      lcr_b  = 6'b00_1_0_1_0;
      chg_at = 5;
      q.push_back(8'h7F);
      set_frame(8'h7F, 7, 1, 1'b1);
      run(165);
      check_tx("stk0_line", 0, 1, 164);
      chk("stk0_par", tr_tx[136], 1);
      chk("stk0_busy160", tr_busy[160], 1);
      chk("stk0_busy161", tr_busy[161], 0);

      // 8E2 back-to-back: 0xA5 then 0x3C
      setup(6'b11_1_1_1_0);
      q.push_back(8'hA5);
      q.push_back(8'h3C);
      run(395);
      set_frame(8'hA5, 8, 1, 1'b0);
      check_tx("8e2_f1_line", 0, 1, 192);
      chk("8e2_pop192", tr_pop[192], 1);
      set_frame(8'h3C, 8, 1, 1'b0);
      check_tx("8e2_f2_line", 192, 193, 394);
      chk("8e2_pops", ones(2, 0, 394), 2);
      chk("8e2_busy_run", ones(1, 1, 384), 384);
      chk("8e2_busy385", tr_busy[385], 0);

      // break during data, released during stop
      setup(6'b11_1_0_0_0);
      q.push_back(8'hFF);
      brk_on = 30; brk_off = 150;
      run(185);
      chk("brk_tx30", tr_tx[30], 1);
      chk("brk_low", ones(0, 31, 150), 0);
      chk("brk_tx151", tr_tx[151], 1);
      chk("brk_tx176", tr_tx[176], 1);
      chk("brk_busy176", tr_busy[176], 1);
      chk("brk_busy177", tr_busy[177], 0);
      chk("brk_pops", ones(2, 0, 184), 1);

      // reset during parity, then ticks frozen 50 clks, then a clean 8O1 frame
      setup(6'b11_0_1_0_0);
      q.push_back(8'h83);
      q.push_back(8'h5A);
      rst_on = 150; rst_off = 151;
      frz_on = 151; frz_off = 201;
      set_frame(8'h83, 8, 1, 1'b0);
      run(385);
      check_tx("rst_f1_line", 0, 1, 150);
      chk("rst_par150", tr_tx[150], 0);
      chk("rst_tx151", tr_tx[151], 1);
      chk("rst_busy151", tr_busy[151], 0);
      chk("rst_pop151", tr_pop[151], 0);
      chk("frz_busy", ones(1, 151, 200), 0);
      chk("frz_tx", ones(0, 151, 200), 50);
      chk("frz_pop", ones(2, 151, 200), 0);
      chk("rst_pop201", tr_pop[201], 1);
      set_frame(8'h5A, 8, 1, 1'b1);
      check_tx("rst_f2_line", 201, 202, 384);
      chk("rst_busy377", tr_busy[377], 1);
      chk("rst_busy378", tr_busy[378], 0);
      chk("rst_pops", ones(2, 0, 384), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
